regfile_param: RTL
==================

# regfile_param

Parametrised, resettable general-purpose register bank for the MIPS datapath: successor of the fixed 32×32 bank, generalised in data width and depth. Adds synchronous reset with a hardware clear sweep, a hardwired zero register, registered read ports with hold-on-disable, and a dropped-write indicator. Sits between decode (read addresses) and write-back (write port).

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
- ZERO_REG, 1, 1: register 0 reads as 0 and ignores writes; 0: register 0 is ordinary

- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- addrRead_A  in  ADDR_W  read port A address
- addrRead_B  in  ADDR_W  read port B address
- addrWrite  in  ADDR_W  write address
- dataIn  in  DATA_W  write data
- write_en  in  1  write request, sampled at posedge
- read_en  in  1  read-port update enable, sampled at posedge
- dataOutA  out  DATA_W  registered read data A
- dataOutB  out  DATA_W  registered read data B
- busy  out  1  clear sweep in progress; bank unusable
- wr_drop  out  1  one-cycle pulse: a write was discarded because busy

## Operation
- Two states: CLEAR, READY. Counter clr_cnt (ADDR_W+1 bits).
- reset high at posedge: state←CLEAR, clr_cnt←0, dataOutA/B←0, busy←1, wr_drop←0. Storage array is not cleared by reset itself.
- CLEAR (reset low): each cycle registers[clr_cnt]←0, clr_cnt←clr_cnt+1. On the cycle writing DEPTH-1: state←READY, busy←0.
- In CLEAR: write_en ignored, storage unchanged by the port; wr_drop←write_en. dataOutA/B held at 0 regardless of read_en.
- READY write: write_en=1 → registers[addrWrite]←dataIn, except addrWrite=0 with ZERO_REG=1 (silently ignored, no wr_drop). wr_drop←0.
- READY read: read_en=1 → dataOutX←value(addrRead_X); read_en=0 → dataOutX holds previous value.
- value(a): 0 if ZERO_REG and a=0; otherwise bypass rule (Configuration) then registers[a].
- Both read ports may address the same register; both get identical data.
- reset asserted mid-sweep or mid-operation restarts the sweep from address 0.

## Timing
- Read latency: 1 cycle (address at posedge N → data valid after posedge N).
- Write visible to array reads from the posedge after the write edge.
- busy rises on the first reset edge; stays high for exactly DEPTH posedges after reset falls (32 with defaults); first usable edge is the (DEPTH+1)th.
- wr_drop: registered, high for the cycle after the offending edge; back-to-back drops give a continuous high.
- No combinational path input→output.

## Configuration
- REGFILE_BYPASS_EN defined: in READY, read_en=1 and write_en=1 and addrRead_X==addrWrite (and not the zero register) → dataOutX←dataIn (write-first).
- Undefined: same case returns the pre-write array contents (read-first); the new value appears on the next read.

## Test plan
- Reset 1 cycle, then poll: busy high for 32 edges then 0; read all 32 addresses with read_en=1 → each returns 0x00000000.
- Write 0xDEADBEEF to r5, next cycle read A=5, B=5 → both 0xDEADBEEF one cycle later; read_en=0 with A=0 → dataOutA stays 0xDEADBEEF.
- ZERO_REG=1: write 0x12345678 to r0, read r0 → 0x00000000, wr_drop stays 0.
- Same-edge write r7=0xA5A5A5A5 and read A=7 (r7 previously 0x11111111) → 0xA5A5A5A5 with REGFILE_BYPASS_EN, 0x11111111 without; following read → 0xA5A5A5A5 either way.
- write_en=1 during sweep (cycle 3 after reset) → wr_drop pulses 1 cycle, target register reads 0 after sweep.
- Fill r1..r31 with nonzero, assert reset mid-sweep at cycle 10, release → busy for full 32 edges, all registers read 0.

Source files
------------

// File: rtl/regfile_param.sv
// Parametrised MIPS register bank; zero register and post-reset hardware clear sweep.
// Latency: 1-cycle registered reads; busy for DEPTH cycles after reset; optional write-first bypass (REGFILE_BYPASS_EN).
// Backpressure: none. Writes arriving while busy are discarded and reported on wr_drop.
module regfile_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addrRead_A,
    input  logic [ADDR_W-1:0] addrRead_B,
    input  logic [ADDR_W-1:0] addrWrite,
    input  logic [DATA_W-1:0] dataIn,
    input  logic              write_en,
    input  logic              read_en,
    output logic [DATA_W-1:0] dataOutA,
    output logic [DATA_W-1:0] dataOutB,
    output logic              busy,
    output logic              wr_drop
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] CLR_LAST = (ADDR_W+1)'(DEPTH - 1);

    typedef enum logic {CLEAR, READY} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W:0]     clr_cnt, clr_nxt;
    logic                busy_nxt, drop_nxt;
    logic [DATA_W-1:0]   out_a_nxt, out_b_nxt;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_wa;
    logic [DATA_W-1:0]   mem_wd;
    logic [DATA_W-1:0]   registers [DEPTH];
    logic [DATA_W-1:0]   rd_a_val, rd_b_val;
    logic                zero_a, zero_b, byp_a, byp_b;

    assign zero_a = ZERO_REG && (addrRead_A == '0);
    assign zero_b = ZERO_REG && (addrRead_B == '0);

`ifdef REGFILE_BYPASS_EN
    assign byp_a = write_en && (addrRead_A == addrWrite);
    assign byp_b = write_en && (addrRead_B == addrWrite);
`else
    assign byp_a = 1'b0;
    assign byp_b = 1'b0;
`endif

    // Zero register wins over the bypass so r0 never echoes a discarded write.
    assign rd_a_val = zero_a ? '0 : (byp_a ? dataIn : registers[addrRead_A]);
    assign rd_b_val = zero_b ? '0 : (byp_b ? dataIn : registers[addrRead_B]);

    always_comb begin
        state_nxt = state;
        clr_nxt   = clr_cnt;
        busy_nxt  = busy;
        drop_nxt  = 1'b0;
        out_a_nxt = dataOutA;
        out_b_nxt = dataOutB;
        mem_we    = 1'b0;
        mem_wa    = addrWrite;
        mem_wd    = dataIn;
        case (state)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_wa    = clr_cnt[ADDR_W-1:0];
                mem_wd    = '0;
                clr_nxt   = clr_cnt + 1'b1;
                drop_nxt  = write_en;
                out_a_nxt = '0;
                out_b_nxt = '0;
                busy_nxt  = 1'b1;
                if (clr_cnt == CLR_LAST) begin
                    state_nxt = READY;
                    busy_nxt  = 1'b0;
                end
            end
            READY: begin
                busy_nxt = 1'b0;
                mem_we   = write_en && !(ZERO_REG && (addrWrite == '0));
                if (read_en) begin
                    out_a_nxt = rd_a_val;
                    out_b_nxt = rd_b_val;
                end
            end
            default: state_nxt = CLEAR;
        endcase
        // Reset alone never touches storage; the sweep that follows does.
        if (reset)
            mem_we = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= CLEAR;
            clr_cnt  <= '0;
            dataOutA <= '0;
            dataOutB <= '0;
            busy     <= 1'b1;
            wr_drop  <= 1'b0;
        end else begin
            state    <= state_nxt;
            clr_cnt  <= clr_nxt;
            dataOutA <= out_a_nxt;
            dataOutB <= out_b_nxt;
            busy     <= busy_nxt;
            wr_drop  <= drop_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            registers[mem_wa] <= mem_wd;
    end
endmodule
